freq_generator: RTL and testbench

- Programmable square-wave source. It is the transmit-side counterpart of the frequency counter: it produces the test signal that the counter measures.
- It accepts a requested frequency in Hz and computes the half-period in clock cycles with an iterative restoring divider.
- It then drives a 50 % duty square wave on signalOut.
- It is used on-board as a self-test stimulus for the counter and as a general clock-derived tone source.

---
 rtl/freq_generator.sv | 200 ++++++++++++++++++++
 tb/tb_freq_generator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_generator.sv
`timescale 1ns/1ps
// freq_generator: programmable 50 % duty square-wave source.
//
// A request in Hz is range-checked, then converted to a half-period in clock
// cycles by an iterative restoring divider (one quotient bit per cycle), after
// which the output toggles every halfPeriod cycles.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   freqIn     requested frequency in Hz, sampled when load is accepted
//   load       single-cycle request strobe, ignored while busy
//   busy       divider running
//   error      last accepted request was out of range (0 or above CLK_HZ/2)
//   signalOut  generated square wave
//   edgeCount  (FREQ_GEN_EDGE_COUNT_EN only) rising edges of signalOut since
//              the last accepted load, wrapping
//
// Optional feature macro: FREQ_GEN_EDGE_COUNT_EN.
module freq_generator #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned WIDTH  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] freqIn,
  input  logic             load,
  output logic             busy,
  output logic             error,
  output logic             signalOut
`ifdef FREQ_GEN_EDGE_COUNT_EN
  ,
  output logic [WIDTH-1:0] edgeCount
`endif
);

  localparam int unsigned      IterW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MaxFreq  = WIDTH'(CLK_HZ / 2);
  localparam logic [WIDTH-1:0] Dividend = WIDTH'(CLK_HZ);
  localparam logic [IterW-1:0] LastIter = IterW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StDivide, StRun} state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [IterW-1:0] iter_q, iter_d;
  logic [WIDTH-1:0] half_q, half_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic             error_q, error_d;
  logic             sig_q, sig_d;
`ifdef FREQ_GEN_EDGE_COUNT_EN
  logic [WIDTH-1:0] edge_q, edge_d;
`endif

  logic             accept;
  logic             req_valid;
  logic             div_done;
  logic             phase_wrap;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] rem_diff;
  logic             rem_fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_shift;
  logic             unused_diff_bit;

  assign accept     = load && (state_q != StDivide);
  assign req_valid  = (freqIn != '0) && (freqIn <= MaxFreq);
  assign div_done   = (state_q == StDivide) && (iter_q == LastIter);
  assign phase_wrap = (phase_q == half_q - WIDTH'(1));

  // Restoring step: dividend bits leave the top of quot_q while quotient bits
  // enter at the bottom. A valid divisor is at most CLK_HZ < 2^WIDTH, so the
  // remainder always fits in WIDTH bits; the borrow out of the widened
  // subtraction decides whether the trial subtraction is kept.
  assign rem_shift       = {rem_q, quot_q[WIDTH-1]};
  assign rem_diff        = {1'b0, rem_shift} - {1'b0, divisor_q};
  assign rem_fits        = ~rem_diff[WIDTH+1];
  assign rem_next        = rem_fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_shift      = {quot_q[WIDTH-2:0], rem_fits};
  assign unused_diff_bit = rem_diff[WIDTH];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = req_valid ? StDivide : StIdle;
    end else if (div_done) begin
      state_d = StRun;
    end
  end

  // Datapath next-state
  always_comb begin
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    iter_d    = iter_q;
    half_d    = half_q;
    phase_d   = phase_q;
    error_d   = error_q;
    sig_d     = sig_q;
`ifdef FREQ_GEN_EDGE_COUNT_EN
    edge_d    = edge_q;
`endif
    if (accept) begin
      // Any accepted request abandons the current waveform at once.
      error_d = ~req_valid;
      sig_d   = 1'b0;
      phase_d = '0;
`ifdef FREQ_GEN_EDGE_COUNT_EN
      edge_d  = '0;
`endif
      if (req_valid) begin
        divisor_d = {freqIn, 1'b0};
        rem_d     = '0;
        quot_d    = Dividend;
        iter_d    = '0;
      end
    end else begin
      case (state_q)
        StDivide: begin
          rem_d  = rem_next;
          quot_d = quot_shift;
          iter_d = iter_q + IterW'(1);
          if (div_done) begin
            half_d  = quot_shift;
            phase_d = '0;
            sig_d   = 1'b0;
          end
        end
        StRun: begin
          if (phase_wrap) begin
            phase_d = '0;
            sig_d   = ~sig_q;
`ifdef FREQ_GEN_EDGE_COUNT_EN
            if (!sig_q) begin
              edge_d = edge_q + WIDTH'(1);
            end
`endif
          end else begin
            phase_d = phase_q + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      iter_q    <= '0;
      half_q    <= '0;
      phase_q   <= '0;
      error_q   <= 1'b0;
      sig_q     <= 1'b0;
`ifdef FREQ_GEN_EDGE_COUNT_EN
      edge_q    <= '0;
`endif
    end else begin
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      iter_q    <= iter_d;
      half_q    <= half_d;
      phase_q   <= phase_d;
      error_q   <= error_d;
      sig_q     <= sig_d;
`ifdef FREQ_GEN_EDGE_COUNT_EN
      edge_q    <= edge_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_q == StDivide);
    error     = error_q;
    signalOut = sig_q;
`ifdef FREQ_GEN_EDGE_COUNT_EN
    edgeCount = edge_q;
`endif
  end

endmodule

// File: tb/tb_freq_generator.sv
`timescale 1ns/1ps
module tb_freq_generator;

  localparam int unsigned ClkHz = 1000000;
  localparam int unsigned Width = 32;

  logic              clock  = 1'b0;
  logic              reset  = 1'b1;
  logic              load   = 1'b0;
  logic [Width-1:0]  freqIn = '0;
  logic              busy;
  logic              error;
  logic              signalOut;
`ifdef FREQ_GEN_EDGE_COUNT_EN
  logic [Width-1:0]  edgeCount;
`endif

  freq_generator #(
    .CLK_HZ(ClkHz),
    .WIDTH (Width)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .freqIn   (freqIn),
    .load     (load),
    .busy     (busy),
    .error    (error),
    .signalOut(signalOut)
`ifdef FREQ_GEN_EDGE_COUNT_EN
    ,
    .edgeCount(edgeCount)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 dividing, 2 running. In RUN, after k clocks
  // the output has toggled floor(k/Q) times; its level is the parity of that
  // and the rising-edge count is ceil(toggles/2).
  int unsigned m_mode  = 0;
  int unsigned m_left  = 0;
  int unsigned m_q     = 1;
  int unsigned m_k     = 0;
  int unsigned m_edges = 0;
  bit          m_err   = 1'b0;
  bit          m_sig   = 1'b0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_mode = 0; m_err = 0; m_sig = 0; m_k = 0; m_edges = 0;
      end else if (load && m_mode != 1) begin
        if (freqIn >= 1 && freqIn <= ClkHz / 2) begin
          m_mode = 1;
          m_left = Width;
          m_q    = ClkHz / (2 * int'(freqIn));
          m_err  = 0;
        end else begin
          m_mode = 0;
          m_err  = 1;
        end
        m_sig = 0; m_k = 0; m_edges = 0;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 2; m_k = 0; m_sig = 0;
        end
      end else if (m_mode == 2) begin
        int unsigned toggles;
        m_k++;
        toggles = m_k / m_q;
        m_sig   = toggles[0];
        m_edges = (toggles + 1) / 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && chk_en) begin
        check("model_busy", busy, (m_mode == 1));
        check("model_error", error, m_err);
        check("model_signal", signalOut, m_sig);
`ifdef FREQ_GEN_EDGE_COUNT_EN
        check("model_edges", edgeCount, m_edges);
`endif
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_load(input logic [Width-1:0] f);
    load   = 1'b1;
    freqIn = f;
    step();
    load   = 1'b0;
    freqIn = $urandom;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait_sig(input logic lvl, input int limit, output int n);
    n = 0;
    while (signalOut !== lvl && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rises;
    logic prev;

    step(3);
    check("reset_busy", busy, 0);
    check("reset_error", error, 0);
    check("reset_signal", signalOut, 0);
`ifdef FREQ_GEN_EDGE_COUNT_EN
    check("reset_edges", edgeCount, 0);
`endif
    reset  = 1'b0;
    chk_en = 1'b1;
    step(2);

    // 1 kHz at 1 MHz clock: Q = 500
    do_load(1000);
    wait_busy(n);
    check("busy_len_1000", n, 32);
    wait_sig(1'b1, 2000, n);
    check("first_rise_1000", n, 500);
    wait_sig(1'b0, 2000, n);
    check("high_1000", n, 500);
    wait_sig(1'b1, 2000, n);
    check("low_1000", n, 500);

    // Maximum frequency: Q = 1, toggles every clock
    do_load(500000);
    wait_busy(n);
    check("busy_len_max", n, 32);
    check("q1_start", signalOut, 0);
    step(); check("q1_t1", signalOut, 1);
    step(); check("q1_t2", signalOut, 0);
    step(); check("q1_t3", signalOut, 1);

    // Out of range
    do_load(500001);
    check("over_error", error, 1);
    check("over_busy", busy, 0);
    check("over_signal", signalOut, 0);
    step(5);
    check("over_busy_later", busy, 0);
    do_load(0);
    check("zero_error", error, 1);
    check("zero_busy", busy, 0);

    // 3 Hz (Q=166666) with an ignored load while dividing
    do_load(3);
    check("err_cleared", error, 0);
    step(5);
    do_load(1000);
    wait_busy(n);
    check("busy_rest_ignored", n, 26);
    rises = 0;
    prev  = signalOut;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (signalOut && !prev) rises++;
      prev = signalOut;
    end
    check("slow_no_rise", rises, 0);

    // Re-load while running
    do_load(1000);
    wait_busy(n);
    step(700);
    check("run_high_700", signalOut, 1);
    do_load(250000);
    check("reload_signal", signalOut, 0);
    check("reload_busy", busy, 1);
    wait_busy(n);
    check("busy_len_250k", n, 32);
    wait_sig(1'b1, 100, n);
    check("first_rise_250k", n, 2);
    wait_sig(1'b0, 100, n);
    check("high_250k", n, 2);
    wait_sig(1'b1, 100, n);
    check("low_250k", n, 2);

    do_load(0);
    check("err_again", error, 1);
    do_load(250000);
    check("err_clear_valid", error, 0);

`ifdef FREQ_GEN_EDGE_COUNT_EN
    do_load(1000);
    wait_busy(n);
    step(10000);
    check("edges_10000", edgeCount, 10);
    do_load(1000);
    check("edges_cleared", edgeCount, 0);
`endif

    // Asynchronous reset mid-divide
    do_load(1000);
    step(10);
    reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_signal", signalOut, 0);
    step(2);
    reset = 1'b0;
    step(50);
    check("post_rst_busy", busy, 0);
    check("post_rst_signal", signalOut, 0);

    // Randomized requests with occasional stray loads
    for (int it = 0; it < 40; it++) begin
      logic [Width-1:0] f;
      int unsigned len;
      if ($urandom_range(0, 7) == 0) begin
        f = ($urandom_range(0, 1) == 0) ? '0 : (ClkHz / 2 + 1 + $urandom_range(0, 1000));
      end else begin
        f = $urandom_range(10000, 500000);
      end
      do_load(f);
      len = $urandom_range(20, 200);
      for (int i = 0; i < int'(len); i++) begin
        if ($urandom_range(0, 49) == 0) begin
          load   = 1'b1;
          freqIn = $urandom_range(5000, 500000);
          step();
          load   = 1'b0;
        end else begin
          step();
        end
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
